// File: rtl/approx_adder_err_monitor.sv
// approx_adder_err_monitor
// Consumer-side checker for approximate W-bit adders. Each accepted sample
// (a, b, cin, approximate sum) is compared against the exact sum. Error metrics
// are accumulated over a window of 2^WIN_LOG2 samples. Each window's metrics are
// then offered through a valid/ready report port.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   clear          synchronous abort of the current window (highest priority)
//   in_valid/ready sample handshake; in_a, in_b, in_cin, in_sum sample payload
//   rpt_valid/ready report handshake
//   rpt_err_cnt    samples with nonzero error distance
//   rpt_sum_ed     sum of error distances
//   rpt_max_ed     maximum error distance
//   rpt_mean_ed    rpt_sum_ed >> WIN_LOG2 (truncating)
module approx_adder_err_monitor #(
   parameter int unsigned W        = 16,
   parameter int unsigned WIN_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_a,
   input  logic [W-1:0]          in_b,
   input  logic                  in_cin,
   input  logic [W-1:0]          in_sum,
   output logic                  rpt_valid,
   input  logic                  rpt_ready,
   output logic [WIN_LOG2:0]     rpt_err_cnt,
   output logic [W+WIN_LOG2-1:0] rpt_sum_ed,
   output logic [W-1:0]          rpt_max_ed,
   output logic [W-1:0]          rpt_mean_ed
);

   typedef enum logic [1:0] {StRun, StDrain, StReport} state_t;

   state_t                r_state;
   logic [WIN_LOG2-1:0]   r_acc_cnt;
   logic [WIN_LOG2:0]     r_acc_err;
   logic [W+WIN_LOG2-1:0] r_acc_sum;
   logic [W-1:0]          r_acc_max;

   logic                  r_s1_valid;
   logic [W-1:0]          r_s1_a;
   logic [W-1:0]          r_s1_b;
   logic                  r_s1_cin;
   logic [W-1:0]          r_s1_sum;
   logic                  r_s2_valid;
   logic [W-1:0]          r_s2_ed;

   logic                  r_rpt_valid;
   logic [WIN_LOG2:0]     r_rpt_err;
   logic [W+WIN_LOG2-1:0] r_rpt_sum;
   logic [W-1:0]          r_rpt_max;

   logic                  w_accept;
   logic [W-1:0]          w_exact;
   logic [W-1:0]          w_ed;

   // clear wins over a simultaneous sample transfer
   assign w_accept = in_valid && in_ready && !clear;

   // Carry-out intentionally dropped: the adder under test has none
   assign w_exact = r_s1_a + r_s1_b + {{(W-1){1'b0}}, r_s1_cin};
   assign w_ed    = (w_exact >= r_s1_sum) ? (w_exact - r_s1_sum) : (r_s1_sum - w_exact);

   // S1 captures the raw sample, S2 holds its error distance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_cin   <= 1'b0;
         r_s1_sum   <= '0;
         r_s2_valid <= 1'b0;
         r_s2_ed    <= '0;
      end else if (clear) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_a   <= in_a;
            r_s1_b   <= in_b;
            r_s1_cin <= in_cin;
            r_s1_sum <= in_sum;
         end
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_ed <= w_ed;
         end
      end
   end

   // Window FSM, accumulators and registered report outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StRun;
         r_acc_cnt   <= '0;
         r_acc_err   <= '0;
         r_acc_sum   <= '0;
         r_acc_max   <= '0;
         r_rpt_valid <= 1'b0;
         r_rpt_err   <= '0;
         r_rpt_sum   <= '0;
         r_rpt_max   <= '0;
      end else if (clear) begin
         // Report payload is kept; only its valid is dropped
         r_state     <= StRun;
         r_acc_cnt   <= '0;
         r_acc_err   <= '0;
         r_acc_sum   <= '0;
         r_acc_max   <= '0;
         r_rpt_valid <= 1'b0;
      end else begin
         if (r_s2_valid) begin
            r_acc_err <= r_acc_err + {{WIN_LOG2{1'b0}}, (r_s2_ed != '0)};
            r_acc_sum <= r_acc_sum + {{WIN_LOG2{1'b0}}, r_s2_ed};
            if (r_s2_ed > r_acc_max) begin
               r_acc_max <= r_s2_ed;
            end
         end
         unique case (r_state)
            StRun: begin
               if (w_accept) begin
                  r_acc_cnt <= r_acc_cnt + 1'b1;
                  if (&r_acc_cnt) begin
                     r_state <= StDrain;
                  end
               end
            end
            StDrain: begin
               // Pipeline empty means the last sample is in the accumulators
               if (!r_s1_valid && !r_s2_valid) begin
                  r_rpt_err   <= r_acc_err;
                  r_rpt_sum   <= r_acc_sum;
                  r_rpt_max   <= r_acc_max;
                  r_rpt_valid <= 1'b1;
                  r_state     <= StReport;
               end
            end
            StReport: begin
               if (rpt_ready) begin
                  r_rpt_valid <= 1'b0;
                  r_acc_err   <= '0;
                  r_acc_sum   <= '0;
                  r_acc_max   <= '0;
                  r_state     <= StRun;
               end
            end
            default: r_state <= StRun;
         endcase
      end
   end

   assign in_ready    = (r_state == StRun);
   assign rpt_valid   = r_rpt_valid;
   assign rpt_err_cnt = r_rpt_err;
   assign rpt_sum_ed  = r_rpt_sum;
   assign rpt_max_ed  = r_rpt_max;
   assign rpt_mean_ed = r_rpt_sum[W+WIN_LOG2-1:WIN_LOG2];

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Bench for approx_adder_err_monitor: a 4-sample-window instance for directed
// cases and a 16-sample-window instance for a random exact-adder stream.
// Expected reports are queued as samples are accepted and compared on transfer.
module tb_approx_adder_err_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // Instance with WIN_LOG2 = 2
   logic        clear, in_valid, in_ready, in_cin, rpt_valid, rpt_ready;
   logic [15:0] in_a, in_b, in_sum, rpt_max_ed, rpt_mean_ed;
   logic [2:0]  rpt_err_cnt;
   logic [17:0] rpt_sum_ed;

   // Instance with WIN_LOG2 = 4
   logic        clear4, in_valid4, in_ready4, in_cin4, rpt_valid4, rpt_ready4;
   logic [15:0] in_a4, in_b4, in_sum4, rpt_max_ed4, rpt_mean_ed4;
   logic [4:0]  rpt_err_cnt4;
   logic [19:0] rpt_sum_ed4;

   approx_adder_err_monitor #(.W(16), .WIN_LOG2(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sum(in_sum),
      .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
      .rpt_err_cnt(rpt_err_cnt), .rpt_sum_ed(rpt_sum_ed),
      .rpt_max_ed(rpt_max_ed), .rpt_mean_ed(rpt_mean_ed)
   );

   approx_adder_err_monitor #(.W(16), .WIN_LOG2(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .clear(clear4),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4), .in_sum(in_sum4),
      .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready4),
      .rpt_err_cnt(rpt_err_cnt4), .rpt_sum_ed(rpt_sum_ed4),
      .rpt_max_ed(rpt_max_ed4), .rpt_mean_ed(rpt_mean_ed4)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] err;
      logic [31:0] sum;
      logic [15:0] max;
   } rpt_t;

   rpt_t exp_q[$];
   rpt_t exp4_q[$];
   rpt_t m_acc, m4_acc, mon_e, mon4_e;
   int   m_cnt = 0, m4_cnt = 0, n_rpt4 = 0;

   function automatic logic [15:0] ed_of(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic [15:0] s);
      logic [15:0] ex;
      ex = a + b + {15'd0, cin};
      return (ex >= s) ? (ex - s) : (s - ex);
   endfunction

   task automatic model_add(input logic [15:0] ed);
      if (ed != 16'd0) m_acc.err += 32'd1;
      m_acc.sum += {16'd0, ed};
      if (ed > m_acc.max) m_acc.max = ed;
      m_cnt++;
      if (m_cnt == 4) begin
         exp_q.push_back(m_acc);
         m_acc = '0;
         m_cnt = 0;
      end
   endtask

   task automatic model4_add(input logic [15:0] ed);
      if (ed != 16'd0) m4_acc.err += 32'd1;
      m4_acc.sum += {16'd0, ed};
      if (ed > m4_acc.max) m4_acc.max = ed;
      m4_cnt++;
      if (m4_cnt == 16) begin
         exp4_q.push_back(m4_acc);
         m4_acc = '0;
         m4_cnt = 0;
      end
   endtask

   // Offer one sample; returns at 1ns after the accepting edge
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] s);
      int k = 0;
      in_a = a; in_b = b; in_cin = cin; in_sum = s; in_valid = 1'b1;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         check("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
         return;
      end
      model_add(ed_of(a, b, cin, s));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Report monitors: a transfer seen at negedge completes at the next posedge
   always @(negedge clk) begin
      if (rst_n && rpt_valid && rpt_ready && !clear) begin
         if (exp_q.size() == 0) begin
            check("rpt_unexpected", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rpt_err_cnt", 64'(rpt_err_cnt), 64'(mon_e.err));
            check("rpt_sum_ed", 64'(rpt_sum_ed), 64'(mon_e.sum));
            check("rpt_max_ed", 64'(rpt_max_ed), 64'(mon_e.max));
            check("rpt_mean_ed", 64'(rpt_mean_ed), 64'(mon_e.sum >> 2) & 64'hFFFF);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && rpt_valid4 && rpt_ready4 && !clear4) begin
         n_rpt4++;
         if (exp4_q.size() == 0) begin
            check("rpt4_unexpected", 64'd1, 64'd0);
         end else begin
            mon4_e = exp4_q.pop_front();
            check("rpt4_err_cnt", 64'(rpt_err_cnt4), 64'(mon4_e.err));
            check("rpt4_sum_ed", 64'(rpt_sum_ed4), 64'(mon4_e.sum));
            check("rpt4_max_ed", 64'(rpt_max_ed4), 64'(mon4_e.max));
            check("rpt4_mean_ed", 64'(rpt_mean_ed4), 64'(mon4_e.sum >> 4) & 64'hFFFF);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sum = '0;
      rpt_ready = 1'b0;
      clear4 = 1'b0; in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_cin4 = 1'b0;
      in_sum4 = '0; rpt_ready4 = 1'b0;
      m_acc = '0; m4_acc = '0;

      // Reset state
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_rpt_valid", 64'(rpt_valid), 64'd0);
      check("rst_rpt_err", 64'(rpt_err_cnt), 64'd0);
      check("rst_rpt_sum", 64'(rpt_sum_ed), 64'd0);
      check("rst_rpt_max", 64'(rpt_max_ed), 64'd0);
      check("rst4_rpt_valid", 64'(rpt_valid4), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Directed window, report held off by backpressure
      send(16'h0001, 16'h0001, 1'b0, 16'h0002);
      send(16'h00FF, 16'h0001, 1'b0, 16'h00F0);
      send(16'h0010, 16'h0010, 1'b1, 16'h0021);
      send(16'h0002, 16'h0002, 1'b0, 16'h0000);
      check("drain_in_ready", 64'(in_ready), 64'd0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("rpt_valid_t%0d", i), 64'(rpt_valid), (i == 3) ? 64'd1 : 64'd0);
      end
      check("dir_err_cnt", 64'(rpt_err_cnt), 64'd2);
      check("dir_sum_ed", 64'(rpt_sum_ed), 64'd20);
      check("dir_max_ed", 64'(rpt_max_ed), 64'd16);
      check("dir_mean_ed", 64'(rpt_mean_ed), 64'd5);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         @(posedge clk); #1;
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_stable", {rpt_valid, rpt_err_cnt, rpt_sum_ed, rpt_max_ed},
               {1'b1, 3'd2, 18'd20, 16'd16});
      end
      in_valid = 1'b0;
      rpt_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 64'(rpt_valid), 64'd0);
      check("bp_release_in_ready", 64'(in_ready), 64'd1);

      // Wrap-around of the exact sum
      send(16'hFFFF, 16'h0001, 1'b0, 16'h0000);
      send(16'hFFFF, 16'h0000, 1'b1, 16'hFFFF);
      send(16'h0000, 16'h0000, 1'b0, 16'h0000);
      send(16'h0005, 16'h0005, 1'b0, 16'h000A);
      begin
         int k = 0;
         while (!rpt_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
         end
         check("wrap_rpt_valid", 64'(rpt_valid), 64'd1);
         check("wrap_max_ed", 64'(rpt_max_ed), 64'hFFFF);
         check("wrap_err_cnt", 64'(rpt_err_cnt), 64'd1);
         @(posedge clk); #1;
         check("wrap_drained", 64'(exp_q.size()), 64'd0);
      end

      // Reset during DRAIN drops the window
      for (int i = 0; i < 4; i++) send(16'h0003, 16'h0003, 1'b0, 16'h0000);
      check("rst_drain_state", 64'(in_ready), 64'd0);
      void'(exp_q.pop_back());
      #2 rst_n = 1'b0;
      #1;
      check("async_in_ready", 64'(in_ready), 64'd1);
      check("async_rpt_valid", 64'(rpt_valid), 64'd0);
      check("async_rpt_max", 64'(rpt_max_ed), 64'd0);
      check("async_rpt_sum", 64'(rpt_sum_ed), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("no_rpt_after_rst", 64'(rpt_valid), 64'd0);
      end
      check("rst_release_in_ready", 64'(in_ready), 64'd1);

      // clear collides with a third sample
      send(16'h0001, 16'h0001, 1'b0, 16'h0000);
      send(16'h0001, 16'h0001, 1'b0, 16'h0000);
      in_a = 16'h0040; in_b = 16'h0001; in_cin = 1'b0; in_sum = 16'h0000;
      in_valid = 1'b1; clear = 1'b1;
      m_acc = '0; m_cnt = 0;
      @(posedge clk); #1;
      clear = 1'b0; in_valid = 1'b0;
      check("clr_in_ready", 64'(in_ready), 64'd1);
      send(16'h0007, 16'h0008, 1'b0, 16'h000F);
      send(16'h1234, 16'h1111, 1'b1, 16'h2346);
      send(16'h0000, 16'h0000, 1'b0, 16'h0000);
      send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("clr_rpt_t%0d", i), 64'(rpt_valid), (i == 3) ? 64'd1 : 64'd0);
      end
      check("clr_err_cnt", 64'(rpt_err_cnt), 64'd0);
      check("clr_sum_ed", 64'(rpt_sum_ed), 64'd0);
      @(posedge clk); #1;
      check("clr_drained", 64'(exp_q.size()), 64'd0);

      // Random exact-adder stream, 3 windows of 16
      begin
         int sent = 0;
         int cyc = 0;
         while (cyc < 3000 && !(sent == 48 && exp4_q.size() == 0 && !rpt_valid4)) begin
            in_valid4 = (sent < 48) && ($urandom_range(0, 3) != 0);
            in_a4 = 16'($urandom);
            in_b4 = 16'($urandom);
            in_cin4 = 1'($urandom_range(0, 1));
            in_sum4 = in_a4 + in_b4 + {15'd0, in_cin4};
            rpt_ready4 = 1'($urandom_range(0, 1));
            if (in_valid4 && in_ready4) begin
               sent++;
               model4_add(ed_of(in_a4, in_b4, in_cin4, in_sum4));
            end
            @(posedge clk); #1;
            cyc++;
         end
         in_valid4 = 1'b0;
         rpt_ready4 = 1'b0;
         check("rnd_sent", 64'(sent), 64'd48);
         check("rnd_reports", 64'(n_rpt4), 64'd3);
         check("rnd_queue_empty", 64'(exp4_q.size()), 64'd0);
      end

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/approx_adder_err_monitor.md
Name: approx_adder_err_monitor

Overview:
- Sequential checker on the consumer side of our approximate parallel-prefix adders.
- Accepts a stream of operand triples (A, B, Cin) together with the approximate sum produced by the adder under test, and computes the exact sum internally.
- Accumulates error metrics over a fixed window of samples and presents them through a report handshake.
- Sits on the bench/FPGA characterisation path behind any W-bit approximate adder (Sum is W bits, no carry-out).

Parameters:
- W, 16, operand and sum width.
- WIN_LOG2, 10, window length is 2^WIN_LOG2 samples (legal range 1..16).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous pulse; aborts the current window.
- in_valid  in  1  sample valid.
- in_ready  out  1  monitor can accept a sample.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in.
- in_sum  in  W  approximate sum from the adder under test.
- rpt_valid  out  1  window report valid.
- rpt_ready  in  1  report consumer ready.
- rpt_err_cnt  out  WIN_LOG2+1  count of samples with nonzero error distance.
- rpt_sum_ed  out  W+WIN_LOG2  sum of error distances.
- rpt_max_ed  out  W  maximum error distance in the window.
- rpt_mean_ed  out  W  rpt_sum_ed >> WIN_LOG2 (truncating mean).

Behaviour:
- Reset: asynchronous active-low, as decided. While rst_n=0 all state clears:
  - FSM goes to RUN; pipeline valids = 0; accumulators = 0.
  - in_ready=1 after release; rpt_valid=0; all rpt_* = 0.
- Transfer rules: a sample transfers when in_valid && in_ready. A report transfers when rpt_valid && rpt_ready.
- Exact result: exact = (in_a + in_b + in_cin) mod 2^W. The carry-out is discarded, because the adder under test exposes no carry-out.
- Error distance: ED = |exact − in_sum|, computed as an unsigned W-bit magnitude (larger minus smaller).
- Pipeline:
  - S1 registers a, b, cin, sum and a valid bit in the cycle after acceptance.
  - S2 computes exact and ED from the S1 registers and updates the accumulators one cycle after S1.
  - A sample accepted at edge t is reflected in the accumulators at edge t+2.
- Accumulator update per S2-valid sample:
  - err_cnt += (ED != 0).
  - sum_ed += ED. Width W+WIN_LOG2 cannot overflow within one window.
  - max_ed = max(max_ed, ED).
- Sample counter: acc_cnt (WIN_LOG2 bits) counts accepted samples.
- FSM states:
  - RUN:
    - in_ready=1.
    - An accept with acc_cnt = 2^WIN_LOG2−1 wraps acc_cnt to 0 and moves to DRAIN.
  - DRAIN:
    - in_ready=0.
    - Waits until both S1 and S2 are empty, which takes 2 cycles.
    - Then latches the accumulators into the rpt_* registers, sets rpt_valid=1 and moves to REPORT.
    - The last sample is accepted at t; rpt_valid rises at t+3.
  - REPORT:
    - in_ready=0; rpt_* hold stable while rpt_valid=1.
    - On a report transfer: rpt_valid=0 in the next cycle, accumulators cleared, return to RUN.
    - rpt_* retain their last values after the handshake.
- clear:
  - In any state: flushes S1/S2 valids, zeroes accumulators and acc_cnt, drops rpt_valid, returns to RUN.
  - clear has priority over a simultaneous sample transfer (the sample is discarded) and over a simultaneous report transfer.
- rpt_ready held high continuously: back-to-back windows are allowed. The only gap is the DRAIN/REPORT bubble of at least 3 cycles.
- in_valid deasserted mid-window: the accumulators simply wait; there is no timeout.
- Reset mid-window or mid-report: all partial results are lost and no report is produced.

Test Plan:
- WIN_LOG2=2, samples (1,1,0,sum 0x0002), (0x00FF,1,0,0x00F0), (0x0010,0x0010,1,0x0021), (2,2,0,0x0000):
  - EDs are 0, 16, 0, 4.
  - Report: rpt_err_cnt=2, rpt_sum_ed=20, rpt_max_ed=16, rpt_mean_ed=5.
  - rpt_valid rises 3 cycles after the 4th accept.
- Wrap-around: (0xFFFF,0x0001,0,sum 0x0000) → ED=0. (0xFFFF,0,1,sum 0xFFFF) → exact 0x0000, ED=0xFFFF; rpt_max_ed=0xFFFF.
- Backpressure: hold rpt_ready=0 for 10 cycles after rpt_valid:
  - in_ready stays 0 and rpt_* stay stable.
  - in_valid pulses during this time are not accepted.
  - Raising rpt_ready gives in_ready=1 in the next cycle, and the new window starts from zero.
- clear asserted after 2 of 4 samples, in the same cycle as a third sample valid:
  - The third sample is dropped and acc_cnt=0.
  - The next 4 samples of all-zero error produce rpt_err_cnt=0, rpt_sum_ed=0.
- rst_n low for 1 cycle during DRAIN:
  - All outputs go to their reset values immediately (asynchronously).
  - rpt_valid never rises for that window, and in_ready=1 after release.
- Random exact-adder stream (in_sum = exact) over 3 windows with WIN_LOG2=4 and random in_valid/rpt_ready: every report shows all zeros, with no lost or duplicated samples (scoreboard count of 16 per window).
